// File: rtl/dds_osc_if.sv
// Oscillator bus: sample tick, gate, tracker config strobe and mixer sample stream.
// master = sequencer/mixer side, slave = oscillator.
interface dds_osc_if #(
  parameter int PHASE_WIDTH = 32,
  parameter int OUT_WIDTH   = 16,
  parameter int VOL_WIDTH   = 8
);
  logic                        sample_en;
  logic                        gate;
  logic                        cfg_valid;
  logic [PHASE_WIDTH-1:0]      cfg_freq;
  logic [1:0]                  cfg_wave;
  logic [7:0]                  cfg_duty;
  logic [VOL_WIDTH-1:0]        cfg_volume;
  logic                        cfg_pending;
  logic signed [OUT_WIDTH-1:0] sample_out;
  logic                        sample_valid;

  // cfg_valid is a one-cycle strobe with no ready; the oscillator always accepts it.
  // sample_valid is a one-cycle strobe with no backpressure.
  modport master (
    output sample_en, gate, cfg_valid, cfg_freq, cfg_wave, cfg_duty, cfg_volume,
    input  cfg_pending, sample_out, sample_valid
  );

  modport slave (
    input  sample_en, gate, cfg_valid, cfg_freq, cfg_wave, cfg_duty, cfg_volume,
    output cfg_pending, sample_out, sample_valid
  );
endinterface

// File: rtl/dds_osc.sv
// DDS voice oscillator (saw / triangle / pulse / noise) with wrap-synchronous config commit.
// Define DDS_OSC_NOISE_EN to build the LFSR noise waveform for wave 3.
module dds_osc #(
  parameter int PHASE_WIDTH = 32,
  parameter int OUT_WIDTH   = 16,
  parameter int VOL_WIDTH   = 8
) (
  input logic     clk,
  input logic     rst_active_high,
  dds_osc_if.slave osc_io
);

  localparam logic [OUT_WIDTH-1:0] WAVE_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] WAVE_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  logic [PHASE_WIDTH-1:0] freq_a_q, freq_s_q;
  logic [1:0]             wave_a_q, wave_s_q;
  logic [7:0]             duty_a_q, duty_s_q;
  logic [VOL_WIDTH-1:0]   vol_a_q, vol_s_q;
  logic                   pending_q;

  logic [PHASE_WIDTH-1:0] phase_q, phase_d;
  logic [PHASE_WIDTH:0]   acc_sum;
  logic                   wrap, commit;

  always_comb begin
    acc_sum = {1'b0, phase_q} + {1'b0, freq_a_q};
    wrap    = osc_io.sample_en & osc_io.gate & acc_sum[PHASE_WIDTH];
    commit  = wrap | ~osc_io.gate;
    phase_d = phase_q;
    if (!osc_io.gate)          phase_d = '0;
    else if (osc_io.sample_en) phase_d = acc_sum[PHASE_WIDTH-1:0];
  end

  // A coincident strobe overwrites the shadow after the old shadow was committed.
  always_ff @(posedge clk or posedge rst_active_high) begin
    if (rst_active_high) begin
      freq_a_q  <= '0;
      wave_a_q  <= '0;
      duty_a_q  <= '0;
      vol_a_q   <= '0;
      freq_s_q  <= '0;
      wave_s_q  <= '0;
      duty_s_q  <= '0;
      vol_s_q   <= '0;
      pending_q <= 1'b0;
    end else begin
      if (commit) begin
        freq_a_q  <= freq_s_q;
        wave_a_q  <= wave_s_q;
        duty_a_q  <= duty_s_q;
        vol_a_q   <= vol_s_q;
        pending_q <= 1'b0;
      end
      if (osc_io.cfg_valid) begin
        freq_s_q  <= osc_io.cfg_freq;
        wave_s_q  <= osc_io.cfg_wave;
        duty_s_q  <= osc_io.cfg_duty;
        vol_s_q   <= osc_io.cfg_volume;
        pending_q <= 1'b1;
      end
    end
  end

  logic [OUT_WIDTH-1:0] noise_w;
`ifdef DDS_OSC_NOISE_EN
  logic [14:0] lfsr_q;

  always_ff @(posedge clk or posedge rst_active_high) begin
    if (rst_active_high) lfsr_q <= 15'h7FFF;
    else if (wrap)       lfsr_q <= {lfsr_q[13:0], lfsr_q[14] ^ lfsr_q[13]};
  end

  assign noise_w = {lfsr_q, {(OUT_WIDTH-15){1'b0}}};
`else
  assign noise_w = '0;
`endif

  // Stage 0 captures the config in force at the tick, so a wrapping tick keeps the old settings.
  logic                 s0_valid_q, s0_on_q;
  logic [1:0]           s0_wave_q;
  logic [7:0]           s0_duty_q;
  logic [VOL_WIDTH-1:0] s0_vol_q;

  always_ff @(posedge clk or posedge rst_active_high) begin
    if (rst_active_high) begin
      phase_q    <= '0;
      s0_valid_q <= 1'b0;
      s0_on_q    <= 1'b0;
      s0_wave_q  <= '0;
      s0_duty_q  <= '0;
      s0_vol_q   <= '0;
    end else begin
      phase_q    <= phase_d;
      s0_valid_q <= osc_io.sample_en;
      if (osc_io.sample_en) begin
        s0_on_q   <= osc_io.gate;
        s0_wave_q <= wave_a_q;
        s0_duty_q <= duty_a_q;
        s0_vol_q  <= vol_a_q;
      end
    end
  end

  logic [OUT_WIDTH:0]   p_top;
  logic [OUT_WIDTH-1:0] tri_t, wave_d;

  always_comb begin
    p_top  = phase_q[PHASE_WIDTH-1 -: OUT_WIDTH+1];
    tri_t  = p_top[OUT_WIDTH] ? ~p_top[OUT_WIDTH-1:0] : p_top[OUT_WIDTH-1:0];
    wave_d = '0;
    case (s0_wave_q)
      2'd0:    wave_d = {~p_top[OUT_WIDTH], p_top[OUT_WIDTH-1 -: OUT_WIDTH-1]};
      2'd1:    wave_d = tri_t ^ WAVE_MIN;
      2'd2:    wave_d = (phase_q[PHASE_WIDTH-1 -: 8] < s0_duty_q) ? WAVE_MAX : WAVE_MIN;
      default: wave_d = noise_w;
    endcase
    if (!s0_on_q) wave_d = '0;
  end

  logic                        s1_valid_q;
  logic signed [OUT_WIDTH-1:0] s1_wave_q;
  logic [VOL_WIDTH-1:0]        s1_vol_q;
  logic signed [OUT_WIDTH+VOL_WIDTH:0] prod;
  logic signed [OUT_WIDTH-1:0] sample_out_q;
  logic                        sample_valid_q;

  assign prod = s1_wave_q * $signed({1'b0, s1_vol_q});

  always_ff @(posedge clk or posedge rst_active_high) begin
    if (rst_active_high) begin
      s1_valid_q     <= 1'b0;
      s1_wave_q      <= '0;
      s1_vol_q       <= '0;
      sample_out_q   <= '0;
      sample_valid_q <= 1'b0;
    end else begin
      s1_valid_q     <= s0_valid_q;
      s1_wave_q      <= wave_d;
      s1_vol_q       <= s0_vol_q;
      sample_valid_q <= s1_valid_q;
      if (s1_valid_q) sample_out_q <= OUT_WIDTH'(prod >>> VOL_WIDTH);
    end
  end

  assign osc_io.cfg_pending  = pending_q;
  assign osc_io.sample_out   = sample_out_q;
  assign osc_io.sample_valid = sample_valid_q;

endmodule

// File: tb/tb_dds_osc.sv
// Directed bench for dds_osc: waveforms, wrap-synchronous config, gating, reset and pipelining.
module tb_dds_osc;
  localparam int PW = 32;
  localparam int OW = 16;
  localparam int VW = 8;
  // sample_en driven after edge k -> captured at k+1 -> sample_valid raised at k+3, seen at 3rd negedge
  localparam int EXP_LAT = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dds_osc_if #(.PHASE_WIDTH(PW), .OUT_WIDTH(OW), .VOL_WIDTH(VW)) osc_io ();

  dds_osc #(.PHASE_WIDTH(PW), .OUT_WIDTH(OW), .VOL_WIDTH(VW)) dut (
    .clk             (clk),
    .rst_active_high (rst),
    .osc_io          (osc_io)
  );

  int checks = 0;
  int errors = 0;
  logic signed [OW-1:0] exp_q[$];
  logic signed [OW-1:0] got;
  int lat;

  function automatic int scale(input int w, input int vol);
    return (w * vol) >>> 8;
  endfunction

  function automatic int saw_of(input logic [31:0] ph);
    return int'(ph[31:16]) - 32768;
  endfunction

  task automatic set_cfg(input logic [31:0] f, input logic [1:0] w, input logic [7:0] d,
                         input logic [7:0] v);
    osc_io.cfg_freq   = f;
    osc_io.cfg_wave   = w;
    osc_io.cfg_duty   = d;
    osc_io.cfg_volume = v;
  endtask

  task automatic strobe_cfg();
    @(posedge clk); #1;
    osc_io.cfg_valid = 1'b1;
    @(posedge clk); #1;
    osc_io.cfg_valid = 1'b0;
  endtask

  // Gate low commits the shadow and zeroes the phase; the voice restarts from phase 0.
  task automatic load_and_commit(input logic [31:0] f, input logic [1:0] w, input logic [7:0] d,
                                 input logic [7:0] v);
    osc_io.gate = 1'b0;
    set_cfg(f, w, d, v);
    strobe_cfg();
    @(posedge clk); #1;
    osc_io.gate = 1'b1;
  endtask

  task automatic tick(input bit also_cfg);
    @(posedge clk); #1;
    osc_io.sample_en = 1'b1;
    osc_io.cfg_valid = also_cfg;
    @(posedge clk); #1;
    osc_io.sample_en = 1'b0;
    osc_io.cfg_valid = 1'b0;
    lat = 0;
    while (lat < 9) begin
      @(negedge clk);
      lat++;
      if (osc_io.sample_valid === 1'b1) break;
    end
    got = osc_io.sample_out;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (osc_io.cfg_pending !== 1'b0) begin errors++; $display("FAIL reset_pending got=%b exp=0", osc_io.cfg_pending); end
    checks++; if (osc_io.sample_out !== 16'sd0) begin errors++; $display("FAIL reset_out got=%0d exp=0", osc_io.sample_out); end
    checks++; if (osc_io.sample_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", osc_io.sample_valid); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_saw();
    logic [31:0] ph;
    int e;
    load_and_commit(32'h1000_0000, 2'd0, 8'd0, 8'd255);
    checks++; if (osc_io.cfg_pending !== 1'b0) begin errors++; $display("FAIL saw_commit_pending got=%b exp=0", osc_io.cfg_pending); end
    ph = '0;
    for (int k = 1; k <= 32; k++) begin
      ph = ph + 32'h1000_0000;
      tick(1'b0);
      e = (k == 1) ? -28560 : scale(saw_of(ph), 255);
      checks++; if (lat !== EXP_LAT) begin errors++; $display("FAIL saw_latency k=%0d got=%0d exp=%0d", k, lat, EXP_LAT); end
      checks++; if (int'(got) !== e) begin errors++; $display("FAIL saw_value k=%0d got=%0d exp=%0d", k, got, e); end
    end
  endtask

  task automatic test_pulse();
    int e;
    load_and_commit(32'h1000_0000, 2'd2, 8'h80, 8'd255);
    for (int k = 1; k <= 16; k++) begin
      tick(1'b0);
      e = ((k % 16) < 8) ? 32639 : -32640;
      checks++; if (int'(got) !== e) begin errors++; $display("FAIL pulse_half k=%0d got=%0d exp=%0d", k, got, e); end
    end
    load_and_commit(32'h1000_0000, 2'd2, 8'h00, 8'd255);
    for (int k = 1; k <= 16; k++) begin
      tick(1'b0);
      checks++; if (int'(got) !== -32640) begin errors++; $display("FAIL pulse_duty0 k=%0d got=%0d exp=-32640", k, got); end
    end
  endtask

  task automatic test_tri();
    int tbl[4];
    tbl = '{0, 32639, -1, -32640};
    load_and_commit(32'h4000_0000, 2'd1, 8'd0, 8'd255);
    for (int k = 0; k < 8; k++) begin
      tick(1'b0);
      checks++; if (int'(got) !== tbl[k % 4]) begin errors++; $display("FAIL tri k=%0d got=%0d exp=%0d", k, got, tbl[k % 4]); end
    end
  endtask

  task automatic test_cfg_midperiod();
    logic [31:0] ph;
    int e;
    load_and_commit(32'h1000_0000, 2'd0, 8'd0, 8'd255);
    ph = '0;
    for (int k = 1; k <= 5; k++) begin ph = ph + 32'h1000_0000; tick(1'b0); end
    set_cfg(32'h2000_0000, 2'd0, 8'd0, 8'd255);
    strobe_cfg();
    checks++; if (osc_io.cfg_pending !== 1'b1) begin errors++; $display("FAIL mid_pending_set got=%b exp=1", osc_io.cfg_pending); end
    for (int k = 6; k <= 15; k++) begin
      ph = ph + 32'h1000_0000;
      tick(1'b0);
      e = scale(saw_of(ph), 255);
      checks++; if (int'(got) !== e) begin errors++; $display("FAIL mid_old_step k=%0d got=%0d exp=%0d", k, got, e); end
    end
    checks++; if (osc_io.cfg_pending !== 1'b1) begin errors++; $display("FAIL mid_pending_hold got=%b exp=1", osc_io.cfg_pending); end
    tick(1'b0);
    checks++; if (int'(got) !== -32640) begin errors++; $display("FAIL mid_wrap_sample got=%0d exp=-32640", got); end
    checks++; if (osc_io.cfg_pending !== 1'b0) begin errors++; $display("FAIL mid_pending_clear got=%b exp=0", osc_io.cfg_pending); end
    tick(1'b0);
    checks++; if (int'(got) !== -24480) begin errors++; $display("FAIL mid_new_step1 got=%0d exp=-24480", got); end
    tick(1'b0);
    checks++; if (int'(got) !== -16320) begin errors++; $display("FAIL mid_new_step2 got=%0d exp=-16320", got); end
  endtask

  task automatic test_cfg_coincident();
    int tbl[8];
    tbl = '{-16320, 0, 16320, -32640, 0, -32640, 0, 32639};
    load_and_commit(32'h4000_0000, 2'd0, 8'd0, 8'd255);
    for (int k = 0; k < 8; k++) begin
      if (k == 1) begin set_cfg(32'h8000_0000, 2'd0, 8'd0, 8'd255); strobe_cfg(); end
      if (k == 3) set_cfg(32'h4000_0000, 2'd1, 8'd0, 8'd255);
      tick(k == 3);
      checks++; if (int'(got) !== tbl[k]) begin errors++; $display("FAIL coincident k=%0d got=%0d exp=%0d", k, got, tbl[k]); end
      if (k == 3) begin
        checks++; if (osc_io.cfg_pending !== 1'b1) begin errors++; $display("FAIL coincident_pending got=%b exp=1", osc_io.cfg_pending); end
      end
      if (k == 5) begin
        checks++; if (osc_io.cfg_pending !== 1'b0) begin errors++; $display("FAIL coincident_pending_clear got=%b exp=0", osc_io.cfg_pending); end
      end
    end
  endtask

  task automatic test_gate_off();
    load_and_commit(32'h1000_0000, 2'd0, 8'd0, 8'd255);
    for (int k = 0; k < 3; k++) tick(1'b0);
    @(posedge clk); #1;
    osc_io.gate = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick(1'b0);
      checks++; if (lat !== EXP_LAT) begin errors++; $display("FAIL gate_off_latency got=%0d exp=%0d", lat, EXP_LAT); end
      checks++; if (int'(got) !== 0) begin errors++; $display("FAIL gate_off_value got=%0d exp=0", got); end
    end
    osc_io.gate = 1'b1;
    tick(1'b0);
    checks++; if (int'(got) !== -28560) begin errors++; $display("FAIL gate_restart got=%0d exp=-28560", got); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ph;
    bit exp_v;
    logic signed [OW-1:0] e;
    load_and_commit(32'h1000_0000, 2'd0, 8'd0, 8'd128);
    ph = '0;
    for (int j = 0; j < 12; j++) begin
      @(posedge clk); #1;
      osc_io.sample_en = (j < 8);
      if (j < 8) begin
        ph = ph + 32'h1000_0000;
        exp_q.push_back(OW'(scale(saw_of(ph), 128)));
      end
      @(negedge clk);
      exp_v = (j >= 3 && j <= 10);
      checks++; if (osc_io.sample_valid !== exp_v) begin errors++; $display("FAIL b2b_valid j=%0d got=%b exp=%b", j, osc_io.sample_valid, exp_v); end
      if (exp_v && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++; if (osc_io.sample_out !== e) begin errors++; $display("FAIL b2b_value j=%0d got=%0d exp=%0d", j, osc_io.sample_out, e); end
      end
    end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL b2b_leftover got=%0d exp=0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_reset_midpipe();
    load_and_commit(32'h1000_0000, 2'd0, 8'd0, 8'd255);
    tick(1'b0);
    @(posedge clk); #1;
    osc_io.sample_en = 1'b1;
    @(posedge clk); #1;
    osc_io.sample_en = 1'b0;
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++; if (osc_io.sample_valid !== 1'b0) begin errors++; $display("FAIL midpipe_valid k=%0d got=%b exp=0", k, osc_io.sample_valid); end
      checks++; if (osc_io.sample_out !== 16'sd0) begin errors++; $display("FAIL midpipe_out k=%0d got=%0d exp=0", k, osc_io.sample_out); end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (osc_io.cfg_pending !== 1'b0) begin errors++; $display("FAIL midpipe_pending got=%b exp=0", osc_io.cfg_pending); end
    load_and_commit(32'h1000_0000, 2'd0, 8'd0, 8'd255);
    tick(1'b0);
    checks++; if (int'(got) !== -28560) begin errors++; $display("FAIL midpipe_restart got=%0d exp=-28560", got); end
  endtask

  task automatic test_wave3();
    int tbl[4];
`ifdef DDS_OSC_NOISE_EN
    tbl = '{-2, -4, -4, -8};
`else
    tbl = '{0, 0, 0, 0};
`endif
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    load_and_commit(32'h8000_0000, 2'd3, 8'd0, 8'd255);
    for (int k = 0; k < 4; k++) begin
      tick(1'b0);
      checks++; if (lat !== EXP_LAT) begin errors++; $display("FAIL wave3_latency k=%0d got=%0d exp=%0d", k, lat, EXP_LAT); end
      checks++; if (int'(got) !== tbl[k]) begin errors++; $display("FAIL wave3_value k=%0d got=%0d exp=%0d", k, got, tbl[k]); end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    osc_io.sample_en  = 1'b0;
    osc_io.gate       = 1'b0;
    osc_io.cfg_valid  = 1'b0;
    osc_io.cfg_freq   = '0;
    osc_io.cfg_wave   = '0;
    osc_io.cfg_duty   = '0;
    osc_io.cfg_volume = '0;
    test_reset();
    test_saw();
    test_pulse();
    test_tri();
    test_cfg_midperiod();
    test_cfg_coincident();
    test_gate_off();
    test_back_to_back();
    test_reset_midpipe();
    test_wave3();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
